// File: rtl/beta_pkg.sv
// Shared types and constants for the Beta fetch-side instruction cache.
// The geometry localparams describe the default 16-line, 4-word configuration.
package beta_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    localparam logic [31:0] RESET = 32'h0000_0000;
    localparam logic [31:0] ILLOP = 32'h0000_0004;
    localparam logic [31:0] XADR  = 32'h0000_0008;

    localparam int DEF_LINES = 16;
    localparam int DEF_WORDS = 4;
    localparam int OFF       = $clog2(DEF_WORDS);
    localparam int IDX       = $clog2(DEF_LINES);
    localparam int TAGW      = 32 - OFF - IDX - 2;

endpackage

// File: rtl/beta_icache_array.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// Reads are combinational; only the valid bits carry a reset.
module beta_icache_array
    import beta_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS,
    parameter int OFFW  = OFF,
    parameter int IDXW  = IDX,
    parameter int TAGB  = TAGW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IDXW-1:0] rd_idx,
    input  logic [OFFW-1:0] rd_off,
    output logic [31:0]     rd_data,
    output logic [TAGB-1:0] rd_tag,
    output logic            rd_valid,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [OFFW-1:0] wr_off,
    input  logic [31:0]     wr_data,
    input  logic            tv_we,
    input  logic [IDXW-1:0] tv_idx,
    input  logic [TAGB-1:0] tv_tag,
    input  logic            tv_valid,
    input  logic            inv_all
);

    logic [31:0]     data_r [LINES][WORDS];
    logic [TAGB-1:0] tag_r  [LINES];
    logic [LINES-1:0] valid_r;

    // Per-word fill write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_r[wr_idx][wr_off] <= wr_data;
        end
    end

    // Tag write, shared by fill start and fill completion
    always_ff @(posedge clk) begin
        if (tv_we) begin
            tag_r[tv_idx] <= tv_tag;
        end
    end

    // Valid bits; a global invalidate beats any single-line write in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {LINES{1'b0}};
        end else if (inv_all) begin
            valid_r <= {LINES{1'b0}};
        end else if (tv_we) begin
            valid_r[tv_idx] <= tv_valid;
        end
    end

    // Combinational lookup port
    always_comb begin
        rd_data  = data_r[rd_idx][rd_off];
        rd_tag   = tag_r[rd_idx];
        rd_valid = valid_r[rd_idx];
    end

endmodule

// File: rtl/beta_icache.sv
// Direct-mapped instruction cache: same-cycle hits, stall on miss, and a
// line refill over a request/beat memory handshake.
module beta_icache
    import beta_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] iAddress,
    output logic [31:0] iData,
    output logic        stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int OFF_B = $clog2(WORDS);
    localparam int IDX_B = $clog2(LINES);
    localparam int LO_B  = OFF_B + 2;
    localparam int TAG_B = 32 - LO_B - IDX_B;

    icache_state_t    state_r;
    logic [OFF_B-1:0] beat_r;
    logic             discard_r;
    logic [IDX_B-1:0] idx_r;
    logic [TAG_B-1:0] ltag_r;

    logic [OFF_B-1:0] addr_off_s;
    logic [IDX_B-1:0] addr_idx_s;
    logic [TAG_B-1:0] addr_tag_s;
    logic [31:0]      rd_data_s;
    logic [TAG_B-1:0] rd_tag_s;
    logic             rd_valid_s;
    logic             hit_s;
    logic             miss_go_s;
    logic             wr_en_s;
    logic             last_s;
    logic             tv_we_s;
    logic [IDX_B-1:0] tv_idx_s;
    logic [TAG_B-1:0] tv_tag_s;
    logic             tv_valid_s;
    logic             unused_s;

    // Address split and hit detection
    always_comb begin
        addr_off_s = iAddress[LO_B-1:2];
        addr_idx_s = iAddress[LO_B+IDX_B-1:LO_B];
        addr_tag_s = iAddress[31:LO_B+IDX_B];
        hit_s      = rd_valid_s && (rd_tag_s == addr_tag_s);
        unused_s   = ^iAddress[1:0];
    end

    // Fetch-side outputs answer in the same cycle as the lookup
    always_comb begin
        iData = rd_data_s;
        stall = (state_r != IDLE) || !hit_s;
    end

    // Array write control: clear the valid bit when a fill starts, set it on the last beat
    always_comb begin
        miss_go_s  = (state_r == IDLE) && !hit_s && !flush;
        wr_en_s    = (state_r == FILL) && mem_rvalid;
        last_s     = wr_en_s && (beat_r == OFF_B'(WORDS - 1));
        tv_idx_s   = addr_idx_s;
        tv_tag_s   = addr_tag_s;
        tv_valid_s = 1'b0;
        if (miss_go_s) begin
            tv_we_s = 1'b1;
        end else if (last_s) begin
            tv_we_s    = 1'b1;
            tv_idx_s   = idx_r;
            tv_tag_s   = ltag_r;
            tv_valid_s = !discard_r;
        end else begin
            tv_we_s = 1'b0;
        end
    end

    // Refill FSM with beat counter, discard flag and memory-side registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            beat_r    <= {OFF_B{1'b0}};
            discard_r <= 1'b0;
            idx_r     <= {IDX_B{1'b0}};
            ltag_r    <= {TAG_B{1'b0}};
            mem_req   <= 1'b0;
            mem_addr  <= RESET;
        end else begin
            case (state_r)
                IDLE: begin
                    if (miss_go_s) begin
                        state_r   <= FILL;
                        idx_r     <= addr_idx_s;
                        ltag_r    <= addr_tag_s;
                        beat_r    <= {OFF_B{1'b0}};
                        discard_r <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_addr  <= {iAddress[31:LO_B], {LO_B{1'b0}}};
                    end
                end
                FILL: begin
                    // A flush mid-fill lets the burst drain but keeps the line invalid
                    if (flush) begin
                        discard_r <= 1'b1;
                    end
                    if (wr_en_s) begin
                        beat_r <= beat_r + OFF_B'(1);
                        if (last_s) begin
                            state_r <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    beta_icache_array #(
        .LINES (LINES),
        .WORDS (WORDS),
        .OFFW  (OFF_B),
        .IDXW  (IDX_B),
        .TAGB  (TAG_B)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (addr_idx_s),
        .rd_off   (addr_off_s),
        .rd_data  (rd_data_s),
        .rd_tag   (rd_tag_s),
        .rd_valid (rd_valid_s),
        .wr_en    (wr_en_s),
        .wr_idx   (idx_r),
        .wr_off   (beat_r),
        .wr_data  (mem_rdata),
        .tv_we    (tv_we_s),
        .tv_idx   (tv_idx_s),
        .tv_tag   (tv_tag_s),
        .tv_valid (tv_valid_s),
        .inv_all  (flush)
    );

endmodule

// File: doc/beta_icache.md
# beta_icache

Direct-mapped instruction cache serving the Beta fetch stage's `iAddress`/`iData` port. It answers hits combinationally in the same cycle and raises `stall` on a miss. While stalled, it refills the line from a backing memory through a request/beat handshake. It sits between the fetch stage and main memory, and the fetch stage holds `iAddress` stable while `stall` is high.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; power of two, at least 2.
- `WORDS`, 4: 32-bit words per line; power of two, at least 2.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous reset, active low.
- `iAddress`  in  32: fetch byte address; bits [1:0] are ignored.
- `iData`  out  32: instruction word at `iAddress`; valid whenever `stall` is 0.
- `stall`  out  1: fetch must hold the PC.
- `flush`  in  1: invalidate all lines; one-cycle pulse.
- `mem_req`  out  1: line-fill request, registered.
- `mem_addr`  out  32: line-aligned fill address, registered.
- `mem_rvalid`  in  1: one fill beat is present this cycle.
- `mem_rdata`  in  32: fill beat data, delivered in ascending word order.

## Operation
- **Address split:**
  - OFF = log2(WORDS), IDX = log2(LINES).
  - Word offset is `iAddress[OFF+1:2]`.
  - Index is `iAddress[OFF+IDX+1:OFF+2]`.
  - Tag is the remaining upper bits: 24 bits at the defaults.
- **Hit:** `valid[idx] && tag[idx]==addr_tag`. `iData = data[idx][off]` combinationally.
- **stall:** `(state != IDLE) || !hit`. It is combinational and asserts in the same cycle as a miss.
- **FSM states:** IDLE and FILL.
  - **IDLE → FILL** on a miss when `flush` is 0. At that edge:
    - latch the index and tag;
    - set `mem_addr` = `{iAddress[31:OFF+2], (OFF+2)'b0}`;
    - set `mem_req` = 1 and `beat` = 0;
    - clear `valid[idx]`.
  - **FILL:** each cycle with `mem_rvalid`, write `mem_rdata` to `data[idx][beat]` and increment `beat`.
  - **FILL → IDLE** on the beat where `beat == WORDS-1`. At that edge:
    - `mem_req` ← 0;
    - write the tag;
    - set `valid[idx]` = 1, unless the fill was flushed (see below).
- **Memory handshake:**
  - `mem_addr` stays stable while `mem_req` is 1.
  - The memory returns exactly WORDS beats, with arbitrary gaps between them.
  - `mem_rvalid` outside FILL is ignored.
- **Flush:**
  - In IDLE, it clears every valid bit at the edge. A miss raised in the same cycle does not start a fill; the lookup is retried in the next cycle.
  - In FILL, it clears every valid bit and sets `discard`. The fill runs to completion, but the final valid write is suppressed. The FSM then returns to IDLE, misses again, and refetches.
  - `flush` coinciding with the last beat behaves the same way: flush wins and the line stays invalid.
- **Reset** (asynchronous, including mid-fill):
  - `state` = IDLE, all `valid` = 0, `mem_req` = 0, `mem_addr` = 0, `beat` = 0, `discard` = 0.
  - The data and tag arrays are not reset.
  - An abandoned memory burst after reset is the memory's responsibility; stray beats are ignored.
- Output values just after reset:
  - `stall` = 1, since every lookup misses.
  - `iData` is undefined.

## Timing
- Hit latency: 0 cycles; `iData` is combinational from `iAddress`.
- Miss, with the miss detected in cycle 0:
  - `mem_req` rises in cycle 1.
  - If beats arrive in cycles 1..WORDS, the line is valid in cycle WORDS+1.
  - `stall` drops in cycle WORDS+1.
  - Minimum penalty is WORDS+1 cycles.
- Back-to-back misses: re-entry into FILL takes at least one IDLE cycle.

## Structure
- **Package `beta_pkg`:**
  - `icache_state_t` enum (IDLE, FILL);
  - the Beta vector constants RESET=0x0, ILLOP=0x4, XADR=0x8;
  - the helper localparams OFF, IDX and TAGW derived from the parameters.
- **Sub-module `beta_icache_array`:** holds the tag, valid and data storage.
  - Combinational read port.
  - Per-word write port.
  - Tag/valid write port.
  - Global invalidate.
- **Top level:** holds the FSM, beat counter, `discard` flag and memory-side registers.

## Test plan
Defaults: LINES=16, WORDS=4.
- **Cold miss:** reset, then `iAddress`=0x0; memory answers with beats 0x11, 0x12, 0x13, 0x14 in consecutive cycles.
  - `stall` is 1 immediately.
  - `mem_req` = 1 with `mem_addr` = 0x0.
  - `stall` is 0 after 5 cycles and `iData` = 0x11.
- **Sequential hits:** after the cold miss, `iAddress` = 0x4, 0x8, 0xC.
  - `stall` is 0 each cycle.
  - `iData` = 0x12, 0x13, 0x14.
  - `mem_req` stays 0.
- **Conflict eviction:** fetch 0x100, which maps to index 0.
  - Fill from `mem_addr` 0x100.
  - A following fetch of 0x0 misses again and refills.
- **Gapped beats:** `mem_rvalid` is asserted only on alternate cycles.
  - `mem_addr` stays stable throughout.
  - Exactly 4 words are written.
  - `stall` drops one cycle after the 4th beat.
- **Flush:** pulse `flush` during beat 2 of a fill.
  - The fill completes and `mem_req` drops.
  - The next cycle misses and a new request goes to the same `mem_addr`.
  - A flush pulse together with the last beat gives the same result.
- **Reset mid-fill:** assert `rst_n` low after beat 1.
  - `mem_req` falls immediately.
  - After release, stray `mem_rvalid` beats are ignored.
  - Fetch of 0x0 misses and starts a fresh fill.
